// File: rtl/capture_pkg.sv
// Shared types and default widths for the crank-wheel tooth capture blocks.
// Holds the sync FSM state encoding used by tooth_sync_ctrl.
package capture_pkg;

    localparam int PWIDTH_DEF = 24;
    localparam int TWIDTH_DEF = 6;

    typedef enum logic [2:0] {
        ST_STOP   = 3'd0,
        ST_FIRST  = 3'd1,
        ST_SECOND = 3'd2,
        ST_SEARCH = 3'd3,
        ST_SYNCED = 3'd4
    } state_e;

    // States in which the interval counter holds a meaningful edge-to-edge time
    function automatic logic is_run_state(input state_e s);
        return (s == ST_SECOND) || (s == ST_SEARCH) || (s == ST_SYNCED);
    endfunction

endpackage

// File: rtl/period_meas.sv
// Saturating edge-to-edge interval counter with period latch and reload.
// A reload makes the counter read 1 on the following cycle, so edges N cycles apart latch N.
module period_meas
    import capture_pkg::*;
#(
    parameter int PWIDTH = PWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              reload,
    input  logic              latch,
    output logic [PWIDTH-1:0] count,
    output logic [PWIDTH-1:0] period,
    output logic              sat
);

    localparam logic [PWIDTH-1:0] CNT_ZERO = {PWIDTH{1'b0}};
    localparam logic [PWIDTH-1:0] CNT_ONE  = {{(PWIDTH-1){1'b0}}, 1'b1};
    localparam logic [PWIDTH-1:0] CNT_MAX  = {PWIDTH{1'b1}};

    logic [PWIDTH-1:0] count_r;
    logic [PWIDTH-1:0] period_r;

    // Interval counter: clear, reload to 1, or count up and stick at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (clr) begin
            count_r <= CNT_ZERO;
        end else if (reload) begin
            count_r <= CNT_ONE;
        end else if (count_r != CNT_MAX) begin
            count_r <= count_r + CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    // Period latch captures the pre-reload count on a measuring edge
    always_ff @(posedge clk) begin
        if (rst) begin
            period_r <= CNT_ZERO;
        end else if (latch) begin
            period_r <= count_r;
        end else begin
            period_r <= period_r;
        end
    end

    assign count  = count_r;
    assign period = period_r;
    assign sat    = (count_r == CNT_MAX);

endmodule

// File: rtl/tooth_sync_ctrl.sv
// Missing-tooth wheel synchroniser: measures tooth periods, finds the gap,
// tracks the tooth index and flags tooth-count mismatches and stalls.
module tooth_sync_ctrl
    import capture_pkg::*;
#(
    parameter int PWIDTH = PWIDTH_DEF,
    parameter int TWIDTH = TWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ena,
    input  logic              edge_in,
    input  logic [TWIDTH-1:0] teeth_val,
    output logic [PWIDTH-1:0] period,
    output logic              period_valid,
    output logic [TWIDTH-1:0] tooth_cnt,
    output logic              gap,
    output logic              sync,
    output logic              err_tooth,
    output logic              stall
);

    localparam logic [TWIDTH-1:0] TOOTH_ZERO = {TWIDTH{1'b0}};
    localparam logic [TWIDTH-1:0] TOOTH_ONE  = {{(TWIDTH-1){1'b0}}, 1'b1};

    state_e            state_r, state_nxt_s;
    logic [PWIDTH-1:0] prev_r, prev_nxt_s;
    logic [PWIDTH-1:0] count_s;
    logic              sat_s, run_s, edge_s, sat_evt_s, meas_edge_s, clr_s, is_gap_s;

    logic              period_valid_r, period_valid_nxt_s;
    logic [TWIDTH-1:0] tooth_cnt_r, tooth_cnt_nxt_s;
    logic              gap_r, gap_nxt_s;
    logic              sync_r, sync_nxt_s;
    logic              err_tooth_r, err_tooth_nxt_s;
    logic              stall_r, stall_nxt_s;

    assign run_s       = is_run_state(state_r);
    assign edge_s      = ena & edge_in & (state_r != ST_STOP);
    assign sat_evt_s   = ena & run_s & sat_s;
    assign meas_edge_s = edge_s & run_s & ~sat_s;
    assign clr_s       = ~ena | (state_r == ST_STOP);
    // Extra bit keeps 2*prev from wrapping for large periods
    assign is_gap_s    = ({1'b0, count_s} >= {prev_r, 1'b0});

    period_meas #(.PWIDTH(PWIDTH)) u_meas (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr_s),
        .reload (edge_s),
        .latch  (meas_edge_s),
        .count  (count_s),
        .period (period),
        .sat    (sat_s)
    );

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= ST_STOP;
            prev_r         <= {PWIDTH{1'b0}};
            period_valid_r <= 1'b0;
            tooth_cnt_r    <= TOOTH_ZERO;
            gap_r          <= 1'b0;
            sync_r         <= 1'b0;
            err_tooth_r    <= 1'b0;
            stall_r        <= 1'b0;
        end else begin
            state_r        <= state_nxt_s;
            prev_r         <= prev_nxt_s;
            period_valid_r <= period_valid_nxt_s;
            tooth_cnt_r    <= tooth_cnt_nxt_s;
            gap_r          <= gap_nxt_s;
            sync_r         <= sync_nxt_s;
            err_tooth_r    <= err_tooth_nxt_s;
            stall_r        <= stall_nxt_s;
        end
    end

    // Next-state logic; a saturating edge restarts as if it were the first edge
    always_comb begin
        state_nxt_s = state_r;
        if (!ena) begin
            state_nxt_s = ST_STOP;
        end else begin
            case (state_r)
                ST_STOP:  state_nxt_s = ST_FIRST;
                ST_FIRST: state_nxt_s = edge_s ? ST_SECOND : ST_FIRST;
                ST_SECOND, ST_SEARCH, ST_SYNCED: begin
                    if (sat_evt_s) begin
                        state_nxt_s = edge_s ? ST_SECOND : ST_FIRST;
                    end else if (meas_edge_s) begin
                        if (state_r == ST_SECOND) begin
                            state_nxt_s = ST_SEARCH;
                        end else if (state_r == ST_SEARCH) begin
                            state_nxt_s = is_gap_s ? ST_SYNCED : ST_SEARCH;
                        end else if (is_gap_s) begin
                            state_nxt_s = (tooth_cnt_r == teeth_val) ? ST_SYNCED : ST_SEARCH;
                        end else begin
                            state_nxt_s = (tooth_cnt_r < teeth_val) ? ST_SYNCED : ST_SEARCH;
                        end
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                default: state_nxt_s = ST_STOP;
            endcase
        end
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        period_valid_nxt_s = 1'b0;
        gap_nxt_s          = 1'b0;
        err_tooth_nxt_s    = 1'b0;
        tooth_cnt_nxt_s    = tooth_cnt_r;
        sync_nxt_s         = sync_r;
        stall_nxt_s        = stall_r;
        prev_nxt_s         = prev_r;
        if (!ena) begin
            sync_nxt_s      = 1'b0;
            tooth_cnt_nxt_s = TOOTH_ZERO;
        end else begin
            case (state_r)
                ST_STOP: begin
                    sync_nxt_s      = 1'b0;
                    tooth_cnt_nxt_s = TOOTH_ZERO;
                end
                ST_FIRST: begin
                    stall_nxt_s = edge_s ? 1'b0 : stall_r;
                end
                ST_SECOND, ST_SEARCH, ST_SYNCED: begin
                    if (sat_evt_s) begin
                        stall_nxt_s = 1'b1;
                        sync_nxt_s  = 1'b0;
                    end else if (meas_edge_s) begin
                        stall_nxt_s        = 1'b0;
                        period_valid_nxt_s = 1'b1;
                        prev_nxt_s         = count_s;
                        if (state_r == ST_SEARCH && is_gap_s) begin
                            tooth_cnt_nxt_s = TOOTH_ZERO;
                            gap_nxt_s       = 1'b1;
                            sync_nxt_s      = 1'b1;
                        end else if (state_r == ST_SYNCED) begin
                            if (is_gap_s && tooth_cnt_r == teeth_val) begin
                                tooth_cnt_nxt_s = TOOTH_ZERO;
                                gap_nxt_s       = 1'b1;
                            end else if (!is_gap_s && tooth_cnt_r < teeth_val) begin
                                tooth_cnt_nxt_s = tooth_cnt_r + TOOTH_ONE;
                            end else begin
                                err_tooth_nxt_s = 1'b1;
                                sync_nxt_s      = 1'b0;
                            end
                        end else begin
                            tooth_cnt_nxt_s = tooth_cnt_r;
                        end
                    end else begin
                        stall_nxt_s = stall_r;
                    end
                end
                default: begin
                    sync_nxt_s      = 1'b0;
                    tooth_cnt_nxt_s = TOOTH_ZERO;
                end
            endcase
        end
    end

    assign period_valid = period_valid_r;
    assign tooth_cnt    = tooth_cnt_r;
    assign gap          = gap_r;
    assign sync         = sync_r;
    assign err_tooth    = err_tooth_r;
    assign stall        = stall_r;

endmodule

// File: tb/tb_tooth_sync_ctrl.sv
// Directed self-checking bench for tooth_sync_ctrl: default-width instance for
// sync/error/reset/enable scenarios, 8-bit-period instance for saturation.
module tb_tooth_sync_ctrl;
    import capture_pkg::*;

    localparam int PW  = 24;
    localparam int TW  = 6;
    localparam int SPW = 8;

    logic          clk = 1'b0;
    logic          rst, ena, edge_in;
    logic [TW-1:0] teeth_val;
    logic [PW-1:0] period;
    logic          period_valid, gap, sync, err_tooth, stall;
    logic [TW-1:0] tooth_cnt;

    logic           s_rst, s_ena, s_edge;
    logic [TW-1:0]  s_teeth;
    logic [SPW-1:0] s_period;
    logic           s_valid, s_gap, s_sync, s_err, s_stall;
    logic [TW-1:0]  s_tooth;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    tooth_sync_ctrl #(.PWIDTH(PW), .TWIDTH(TW)) u_dut (
        .clk(clk), .rst(rst), .ena(ena), .edge_in(edge_in), .teeth_val(teeth_val),
        .period(period), .period_valid(period_valid), .tooth_cnt(tooth_cnt),
        .gap(gap), .sync(sync), .err_tooth(err_tooth), .stall(stall)
    );

    tooth_sync_ctrl #(.PWIDTH(SPW), .TWIDTH(TW)) u_sat (
        .clk(clk), .rst(s_rst), .ena(s_ena), .edge_in(s_edge), .teeth_val(s_teeth),
        .period(s_period), .period_valid(s_valid), .tooth_cnt(s_tooth),
        .gap(s_gap), .sync(s_sync), .err_tooth(s_err), .stall(s_stall)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_edge();
        edge_in = 1'b1;
        tick();
        edge_in = 1'b0;
    endtask

    task automatic edge_after(input int n);
        repeat (n - 1) tick();
        send_edge();
    endtask

    task automatic s_edge_after(input int n);
        repeat (n - 1) tick();
        s_edge = 1'b1;
        tick();
        s_edge = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b0; edge_in = 1'b0; teeth_val = 6'd57;
        s_rst = 1'b1; s_ena = 1'b0; s_edge = 1'b0; s_teeth = 6'd57;
        tick(); tick();
        checks++; if (period !== 24'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if ({period_valid, gap, sync, err_tooth, stall} !== 5'b00000) begin errors++; $display("FAIL reset_flags: got %b want 00000", {period_valid, gap, sync, err_tooth, stall}); end
        checks++; if (tooth_cnt !== 6'd0) begin errors++; $display("FAIL reset_tooth: got %0d want 0", tooth_cnt); end
        checks++; if (u_dut.state_r !== ST_STOP) begin errors++; $display("FAIL reset_state: got %0d want %0d", u_dut.state_r, ST_STOP); end
        rst = 1'b0;
    endtask

    task automatic test_first_period();
        ena = 1'b1;
        tick();
        checks++; if (u_dut.state_r !== ST_FIRST) begin errors++; $display("FAIL first_state: got %0d want %0d", u_dut.state_r, ST_FIRST); end
        send_edge();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL first_edge_valid: got %b want 0", period_valid); end
        edge_after(100);
        checks++; if (period_valid !== 1'b1) begin errors++; $display("FAIL second_edge_valid: got %b want 1", period_valid); end
        checks++; if (period !== 24'd100) begin errors++; $display("FAIL second_edge_period: got %0d want 100", period); end
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL second_edge_sync: got %b want 0", sync); end
        tick();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: got %b want 0", period_valid); end
    endtask

    task automatic test_sync();
        edge_after(300);
        checks++; if ({gap, sync, err_tooth} !== 3'b110) begin errors++; $display("FAIL search_gap: got gap/sync/err=%b want 110", {gap, sync, err_tooth}); end
        checks++; if (tooth_cnt !== 6'd0) begin errors++; $display("FAIL search_gap_tooth: got %0d want 0", tooth_cnt); end
        for (int rev = 0; rev < 2; rev++) begin
            for (int k = 1; k <= 57; k++) begin
                edge_after(100);
                checks++; if (tooth_cnt !== 6'(k)) begin errors++; $display("FAIL rev%0d_tooth: got %0d want %0d", rev, tooth_cnt, k); end
                checks++; if ({gap, sync, err_tooth, period_valid} !== 4'b0101) begin errors++; $display("FAIL rev%0d_tooth%0d_flags: got %b want 0101", rev, k, {gap, sync, err_tooth, period_valid}); end
            end
            edge_after(300);
            checks++; if ({gap, sync, err_tooth} !== 3'b110) begin errors++; $display("FAIL rev%0d_gap: got gap/sync/err=%b want 110", rev, {gap, sync, err_tooth}); end
            checks++; if (tooth_cnt !== 6'd0 || period !== 24'd300) begin errors++; $display("FAIL rev%0d_gap_tooth_period: got %0d/%0d want 0/300", rev, tooth_cnt, period); end
        end
    endtask

    task automatic test_err_tooth();
        repeat (40) edge_after(100);
        checks++; if (tooth_cnt !== 6'd40) begin errors++; $display("FAIL err_pre_tooth: got %0d want 40", tooth_cnt); end
        edge_after(300);
        checks++; if ({err_tooth, sync, gap} !== 3'b100) begin errors++; $display("FAIL early_gap: got err/sync/gap=%b want 100", {err_tooth, sync, gap}); end
        checks++; if (u_dut.state_r !== ST_SEARCH) begin errors++; $display("FAIL early_gap_state: got %0d want %0d", u_dut.state_r, ST_SEARCH); end
        tick();
        checks++; if (err_tooth !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %b want 0", err_tooth); end
        repeat (57) edge_after(100);
        checks++; if ({sync, err_tooth, gap} !== 3'b000) begin errors++; $display("FAIL search_no_lock: got sync/err/gap=%b want 000", {sync, err_tooth, gap}); end
        edge_after(300);
        checks++; if ({gap, sync, err_tooth} !== 3'b110 || tooth_cnt !== 6'd0) begin errors++; $display("FAIL resync: got gap/sync/err=%b tooth=%0d want 110 tooth=0", {gap, sync, err_tooth}, tooth_cnt); end
    endtask

    task automatic test_rst_mid();
        repeat (20) edge_after(100);
        checks++; if (tooth_cnt !== 6'd20 || sync !== 1'b1) begin errors++; $display("FAIL pre_rst: got tooth=%0d sync=%b want 20/1", tooth_cnt, sync); end
        repeat (30) tick();
        rst = 1'b1; edge_in = 1'b1;
        tick();
        edge_in = 1'b0;
        checks++; if ({period_valid, gap, sync, err_tooth, stall} !== 5'b00000 || tooth_cnt !== 6'd0 || period !== 24'd0) begin errors++; $display("FAIL mid_rst_outputs: got flags=%b tooth=%0d period=%0d want 0", {period_valid, gap, sync, err_tooth, stall}, tooth_cnt, period); end
        checks++; if (u_dut.state_r !== ST_STOP) begin errors++; $display("FAIL mid_rst_state: got %0d want %0d", u_dut.state_r, ST_STOP); end
        rst = 1'b0;
    endtask

    task automatic test_ena();
        tick();
        send_edge();
        edge_after(100);
        edge_after(300);
        repeat (10) edge_after(100);
        checks++; if (sync !== 1'b1 || tooth_cnt !== 6'd10) begin errors++; $display("FAIL ena_pre: got sync=%b tooth=%0d want 1/10", sync, tooth_cnt); end
        ena = 1'b0;
        tick();
        checks++; if (u_dut.state_r !== ST_STOP || sync !== 1'b0) begin errors++; $display("FAIL ena_drop: got state=%0d sync=%b want %0d/0", u_dut.state_r, sync, ST_STOP); end
        for (int i = 0; i < 3; i++) begin
            edge_after(20);
            checks++; if (period_valid !== 1'b0 || u_dut.state_r !== ST_STOP) begin errors++; $display("FAIL stop_ignores_edge%0d: got valid=%b state=%0d", i, period_valid, u_dut.state_r); end
        end
        ena = 1'b1;
        tick();
        checks++; if (u_dut.state_r !== ST_FIRST) begin errors++; $display("FAIL reenable_state: got %0d want %0d", u_dut.state_r, ST_FIRST); end
        send_edge();
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reenable_first_valid: got %b want 0", period_valid); end
        edge_after(50);
        checks++; if (period_valid !== 1'b1 || period !== 24'd50 || sync !== 1'b0) begin errors++; $display("FAIL reenable_period: got valid=%b period=%0d sync=%b want 1/50/0", period_valid, period, sync); end
    endtask

    task automatic test_stall();
        s_rst = 1'b0; s_ena = 1'b1;
        tick();
        s_edge_after(1);
        s_edge_after(50);
        s_edge_after(120);
        checks++; if (s_sync !== 1'b1 || s_gap !== 1'b1 || s_tooth !== 6'd0) begin errors++; $display("FAIL stall_pre_sync: got sync=%b gap=%b tooth=%0d want 1/1/0", s_sync, s_gap, s_tooth); end
        repeat (254) tick();
        checks++; if (s_stall !== 1'b0 || s_sync !== 1'b1) begin errors++; $display("FAIL stall_early: got stall=%b sync=%b want 0/1", s_stall, s_sync); end
        tick();
        checks++; if (s_stall !== 1'b1 || s_sync !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL stall_set: got stall=%b sync=%b valid=%b want 1/0/0", s_stall, s_sync, s_valid); end
        repeat (5) tick();
        checks++; if (s_stall !== 1'b1) begin errors++; $display("FAIL stall_sticky: got %b want 1", s_stall); end
        s_edge_after(1);
        checks++; if (s_stall !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL stall_clear: got stall=%b valid=%b want 0/0", s_stall, s_valid); end
        s_edge_after(30);
        checks++; if (s_valid !== 1'b1 || s_period !== 8'd30) begin errors++; $display("FAIL stall_restart: got valid=%b period=%0d want 1/30", s_valid, s_period); end
    endtask

    initial begin
        test_reset();
        test_first_period();
        test_sync();
        test_err_tooth();
        test_rst_mid();
        test_ena();
        test_stall();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
